// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_ORIEX   = 4'd12,
        S_ORIWB   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: state-derived alu_op plus funct to alu_ctrl.
// Latency 0; no flow control.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t     i_alu_op,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alu_ctrl,
    output logic        o_funct_illegal
);

    logic [2:0] w_funct_ctrl;

    // Funct legality is independent of alu_op so DECODE can flag it early.
    always_comb begin
        w_funct_ctrl    = ALU_ADD;
        o_funct_illegal = 1'b0;
        case (i_funct)
            FN_ADD:  w_funct_ctrl = ALU_ADD;
            FN_SUB:  w_funct_ctrl = ALU_SUB;
            FN_AND:  w_funct_ctrl = ALU_AND;
            FN_OR:   w_funct_ctrl = ALU_OR;
            FN_SLT:  w_funct_ctrl = ALU_SLT;
            default: o_funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD:   o_alu_ctrl = ALU_ADD;
            ALUOP_SUB:   o_alu_ctrl = ALU_SUB;
            ALUOP_OR:    o_alu_ctrl = ALU_OR;
            ALUOP_FUNCT: o_alu_ctrl = w_funct_ctrl;
            default:     o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback.
// Moore outputs from the state register; pc_en also depends on zero in BEQEX.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int SUPPORT_ORI = 1
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [2:0]  alu_ctrl,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        illegal_op,
    output logic [3:0]  state_o
);

    state_t  r_state;
    state_t  w_next;
    alu_op_t w_alu_op;
    logic    w_pc_write;
    logic    w_branch;
    logic    w_ir_write;
    logic    w_mem_write;
    logic    w_reg_write;
    logic    w_illegal;
    logic    w_funct_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = S_FETCH;
        w_alu_op    = ALUOP_ADD;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                alu_src_b  = 2'b01;
                w_pc_write = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    OP_RTYPE: begin
                        if (w_funct_illegal) w_illegal = 1'b1;
                        else                 w_next    = S_RTYPEEX;
                    end
                    OP_ORI: begin
                        if (SUPPORT_ORI != 0) w_next    = S_ORIEX;
                        else                  w_illegal = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_SUB;
                pc_src    = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            // ori operates on register A with the zero-extended immediate.
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b11;
                w_alu_op  = ALUOP_OR;
                w_next    = S_ORIWB;
            end
            S_ADDIWB, S_ORIWB: w_reg_write = 1'b1;
            S_JEX: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op        (w_alu_op),
        .i_funct         (funct),
        .o_alu_ctrl      (alu_ctrl),
        .o_funct_illegal (w_funct_illegal)
    );

    // Enables are gated by reset_n so they drop the instant reset asserts.
    assign pc_en      = reset_n & (w_pc_write | (w_branch & zero));
    assign ir_write   = reset_n & w_ir_write;
    assign mem_write  = reset_n & w_mem_write;
    assign reg_write  = reset_n & w_reg_write;
    assign illegal_op = reset_n & w_illegal;
    assign state_o    = r_state;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Control FSM for the multicycle MIPS datapath. It is the producer side of the ALU control interface: it generates alu_ctrl and all datapath enables and selects.
- Decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback steps.
- Sits between the instruction register and the datapath. It consumes the ALU zero flag for branches.

Parameters:
- SUPPORT_ORI, 1, when 1 adds the ORIEX/ORIWB states for ori (opcode 6'h0D); when 0, ori is treated as illegal.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- opcode  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag, valid combinationally in the BEQEX state.
- alu_ctrl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- alu_src_a  output  1  0 selects PC, 1 selects register A.
- alu_src_b  output  2  00 selects B, 01 selects constant 4, 10 selects sign-extended imm, 11 selects zero-extended imm.
- pc_src  output  2  00 selects ALU result, 01 selects ALUOut, 10 selects jump target.
- pc_en  output  1  PC register write enable.
- iord  output  1  memory address select: 0 selects PC, 1 selects ALUOut.
- mem_write  output  1  data memory write enable.
- ir_write  output  1  instruction register load enable.
- reg_dst  output  1  0 selects rt, 1 selects rd.
- mem_to_reg  output  1  0 selects ALUOut, 1 selects the data register.
- reg_write  output  1  register file write enable.
- illegal_op  output  1  pulses for one cycle in DECODE on an unsupported opcode or funct.
- state_o  output  4  current state encoding, for debug and verification.

Behaviour:
- Reset:
  - reset_n low forces state to FETCH immediately, regardless of clk, including mid-instruction.
  - While in reset, every enable output (pc_en, ir_write, mem_write, reg_write) is 0 and illegal_op is 0.
  - Select outputs take the FETCH values while in reset.
- Output timing:
  - Moore outputs are decoded from the state register.
  - alu_ctrl is combinational from an internal alu_op[1:0] (state-derived) plus funct.
  - pc_en = pc_write | (branch & zero), combinational.
- States and transitions (each state lasts 1 cycle):
  - FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00, pc_write=1. Next state DECODE.
  - DECODE: alu_src_a=0, alu_src_b=10 (shifted imm is formed in the datapath), alu_op=add.
    - lw/sw (23/2B) go to MEMADR.
    - R-type (00) goes to RTYPEEX.
    - beq (04) goes to BEQEX.
    - addi (08) goes to ADDIEX.
    - ori (0D) goes to ORIEX.
    - j (02) goes to JEX.
    - Any other opcode raises illegal_op and returns to FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, add. lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD: iord=1. Next MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH.
  - MEMWR: iord=1, mem_write=1. Next FETCH.
  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=funct-decoded. Next RTYPEWB.
  - RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next FETCH.
  - BEQEX: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1. Next FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, add. Next ADDIWB.
  - ORIEX: alu_src_b=11, or. Next ORIWB.
  - ADDIWB/ORIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH.
  - JEX: pc_src=10, pc_write=1. Next FETCH.
- Funct decode (R-type):
  - 20 gives 010, 22 gives 110, 24 gives 000, 25 gives 001, 2A gives 111.
  - Any other funct raises illegal_op in DECODE and the FSM returns to FETCH with no writeback.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, ori 4, beq 3, j 3.
- Invariants:
  - At most one of mem_write and reg_write is high in any cycle.
  - ir_write is high only in FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - the state_t enum (4-bit);
  - opcode and funct constants;
  - alu_ctrl constants (ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_AND=3'b000, ALU_OR=3'b001, ALU_SLT=3'b111);
  - alu_op_t.
- One sub-module, alu_decoder: combinational alu_op plus funct to alu_ctrl and funct_illegal.
- The main FSM lives in mips_multicycle_ctrl.

Test Plan:
- Reset then lw (opcode 23): release reset_n → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 and mem_to_reg=1 only in cycle 5; pc_en=1 only in cycle 1.
- R-type add then sub then slt (funct 20, 22, 2A): alu_ctrl=010, 110, 111 in RTYPEEX. reg_dst=1 and reg_write=1 in RTYPEWB.
- beq with zero=1, then with zero=0: in BEQEX, alu_ctrl=110, pc_src=01. pc_en=1 only when zero=1; FSM returns to FETCH after 3 cycles either way.
- sw (2B) and j (02): for sw, mem_write=1 in cycle 4 only and reg_write never asserts. For j, pc_src=10 and pc_en=1 in cycle 3.
- Illegal opcode 3F and illegal funct 3F: illegal_op=1 for one cycle in DECODE, then FETCH. No reg_write or mem_write occurs.
- reset_n pulled low mid-cycle during MEMRD: state_o reads FETCH immediately, before the next clk edge. All enables are 0 while reset is held. After release, the instruction restarts with a normal fetch.
